// File: rtl/mac_iter_sequencer_if.sv
// Control and engine/streamer signals of the MAC iteration sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface mac_iter_sequencer_if #(
    parameter int CNT_LEN   = 1024,
    parameter int NB_ITER_W = 16,
    parameter int SHIFT_W   = 5
);
    localparam int LEN_W = $clog2(CNT_LEN) + 1;

    // register-file control slave side
    logic                 clear_i;
    logic                 start_i;
    logic [NB_ITER_W-1:0] nb_iter_i;
    logic [LEN_W-1:0]     len_i;
    logic [SHIFT_W-1:0]   shift_i;
    logic                 simple_mul_i;
    logic                 busy_o;
    logic                 done_o;
    logic [NB_ITER_W-1:0] iter_idx_o;

    // MAC engine side
    logic                 eng_clear_o;
    logic                 eng_start_o;
    logic                 eng_enable_o;
    logic                 eng_simple_mul_o;
    logic [SHIFT_W-1:0]   eng_shift_o;
    logic [LEN_W-1:0]     eng_len_o;
    logic [LEN_W-1:0]     eng_cnt_i;
    logic                 eng_acc_valid_i;

    // streamer side
    logic                 src_req_start_o;
    logic                 src_ready_i;
    logic                 sink_req_start_o;
    logic                 sink_ready_i;
    logic                 sink_done_i;

    modport master (
        input  clear_i, start_i, nb_iter_i, len_i, shift_i, simple_mul_i,
        output busy_o, done_o, iter_idx_o,
        output eng_clear_o, eng_start_o, eng_enable_o, eng_simple_mul_o,
        output eng_shift_o, eng_len_o,
        input  eng_cnt_i, eng_acc_valid_i,
        output src_req_start_o, sink_req_start_o,
        input  src_ready_i, sink_ready_i, sink_done_i
    );

    modport slave (
        output clear_i, start_i, nb_iter_i, len_i, shift_i, simple_mul_i,
        input  busy_o, done_o, iter_idx_o,
        input  eng_clear_o, eng_start_o, eng_enable_o, eng_simple_mul_o,
        input  eng_shift_o, eng_len_o,
        output eng_cnt_i, eng_acc_valid_i,
        input  src_req_start_o, sink_req_start_o,
        output src_ready_i, sink_ready_i, sink_done_i
    );
endinterface

// File: rtl/mac_iter_sequencer.sv
// Control FSM of the MAC HWPE: runs nb_iter scalar products of len elements,
// driving the source/sink streamers and the MAC engine for each iteration.
module mac_iter_sequencer #(
    parameter int CNT_LEN   = 1024,
    parameter int NB_ITER_W = 16,
    parameter int SHIFT_W   = 5
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    mac_iter_sequencer_if.master ctrl_bus
);
    localparam int LEN_W = $clog2(CNT_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COMPUTE,
        S_WAIT,
        S_UPDATEIDX,
        S_TERMINATE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [NB_ITER_W-1:0] r_nb_iter;
    logic [NB_ITER_W-1:0] r_iter_idx;
    logic [NB_ITER_W-1:0] w_iter_idx_next;
    logic [NB_ITER_W-1:0] w_iter_idx_inc;
    logic [LEN_W-1:0]     r_len;
    logic [SHIFT_W-1:0]   r_shift;
    logic                 r_simple_mul;
    logic                 r_sink_done;
    logic                 w_sink_done_next;
    logic                 w_latch_cfg;
    logic                 w_eng_clear;
    logic                 w_eng_start;
    logic                 w_eng_enable;
    logic                 w_src_req;
    logic                 w_sink_req;
    logic                 w_done;

    assign w_iter_idx_inc = r_iter_idx + NB_ITER_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_iter_idx   <= '0;
            r_sink_done  <= 1'b0;
            r_nb_iter    <= '0;
            r_len        <= '0;
            r_shift      <= '0;
            r_simple_mul <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_iter_idx  <= w_iter_idx_next;
            r_sink_done <= w_sink_done_next;
            if (w_latch_cfg) begin
                r_nb_iter    <= ctrl_bus.nb_iter_i;
                r_len        <= ctrl_bus.len_i;
                r_shift      <= ctrl_bus.shift_i;
                r_simple_mul <= ctrl_bus.simple_mul_i;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_iter_idx_next  = r_iter_idx;
        w_sink_done_next = r_sink_done;
        w_latch_cfg      = 1'b0;
        w_eng_clear      = 1'b0;
        w_eng_start      = 1'b0;
        w_eng_enable     = 1'b0;
        w_src_req        = 1'b0;
        w_sink_req       = 1'b0;
        w_done           = 1'b0;

        if (ctrl_bus.clear_i) begin
            // abort: back to IDLE without a done event
            w_state_next     = S_IDLE;
            w_iter_idx_next  = '0;
            w_sink_done_next = 1'b0;
            w_eng_clear      = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (ctrl_bus.start_i) begin
                        w_latch_cfg      = 1'b1;
                        w_iter_idx_next  = '0;
                        w_sink_done_next = 1'b0;
                        w_eng_clear      = 1'b1;
                        if (ctrl_bus.nb_iter_i == '0 || ctrl_bus.len_i == '0)
                            w_state_next = S_TERMINATE;
                        else
                            w_state_next = S_START;
                    end
                end
                S_START: begin
                    w_src_req  = 1'b1;
                    w_sink_req = 1'b1;
                    if (ctrl_bus.sink_done_i)
                        w_sink_done_next = 1'b1;
                    if (ctrl_bus.src_ready_i && ctrl_bus.sink_ready_i) begin
                        w_eng_start  = 1'b1;
                        w_state_next = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    w_eng_enable = 1'b1;
                    // a sink completion that races the accumulator is kept
                    if (ctrl_bus.sink_done_i)
                        w_sink_done_next = 1'b1;
                    if (ctrl_bus.eng_acc_valid_i && ctrl_bus.eng_cnt_i == r_len)
                        w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    w_eng_enable = 1'b1;
                    if (ctrl_bus.sink_done_i || r_sink_done)
                        w_state_next = S_UPDATEIDX;
                end
                S_UPDATEIDX: begin
                    w_eng_clear      = 1'b1;
                    w_iter_idx_next  = w_iter_idx_inc;
                    w_sink_done_next = 1'b0;
                    if (w_iter_idx_inc == r_nb_iter)
                        w_state_next = S_TERMINATE;
                    else
                        w_state_next = S_START;
                end
                S_TERMINATE: begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign ctrl_bus.busy_o           = (r_state != S_IDLE);
    assign ctrl_bus.done_o           = w_done;
    assign ctrl_bus.iter_idx_o       = r_iter_idx;
    assign ctrl_bus.eng_clear_o      = w_eng_clear;
    assign ctrl_bus.eng_start_o      = w_eng_start;
    assign ctrl_bus.eng_enable_o     = w_eng_enable;
    assign ctrl_bus.eng_simple_mul_o = r_simple_mul;
    assign ctrl_bus.eng_shift_o      = r_shift;
    assign ctrl_bus.eng_len_o        = r_len;
    assign ctrl_bus.src_req_start_o  = w_src_req;
    assign ctrl_bus.sink_req_start_o = w_sink_req;

endmodule

// File: tb/tb_mac_iter_sequencer.sv
// Bench for mac_iter_sequencer: each run precomputes an event timeline
// (request, engine start, accumulator, sink done, index update, done) and checks every cycle against it.
module tb_mac_iter_sequencer;
    localparam int CNT_LEN   = 1024;
    localparam int NB_ITER_W = 16;
    localparam int SHIFT_W   = 5;
    localparam int LEN_W     = $clog2(CNT_LEN) + 1;
    localparam int MAXK      = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mac_iter_sequencer_if #(.CNT_LEN(CNT_LEN), .NB_ITER_W(NB_ITER_W), .SHIFT_W(SHIFT_W)) bus_if ();

    mac_iter_sequencer #(.CNT_LEN(CNT_LEN), .NB_ITER_W(NB_ITER_W), .SHIFT_W(SHIFT_W)) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .ctrl_bus (bus_if)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cur_t = 0;

    // per-iteration environment timing: source/sink ready delays, extra engine cycles, sink-done offset
    int sdly[MAXK], kdly[MAXK], xtra[MAXK], ddl[MAXK];
    // reference timeline, cycles relative to the start_i cycle
    int ev_r[MAXK+1], ev_e[MAXK], ev_f[MAXK], ev_s[MAXK], ev_u[MAXK];
    int ev_d, n_eff;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0d got=%0d want=%0d", tag, cur_t, got, exp);
        end
    endtask

    task automatic set_timing(input int sd, input int kd, input int x, input int dd);
        for (int k = 0; k < MAXK; k++) begin
            sdly[k] = sd; kdly[k] = kd; xtra[k] = x; ddl[k] = dd;
        end
    endtask

    task automatic rand_timing();
        for (int k = 0; k < MAXK; k++) begin
            sdly[k] = int'($urandom_range(0, 4));
            kdly[k] = int'($urandom_range(0, 4));
            xtra[k] = int'($urandom_range(0, 2));
            ddl[k]  = int'($urandom_range(0, 5)) - 2;
        end
    endtask

    // An iteration's index update happens one cycle after both the accumulator
    // result has been taken (WAIT is entered the cycle after) and the sink is done.
    task automatic build_schedule(input int nb, input int ln);
        n_eff = (nb == 0 || ln == 0) ? 0 : nb;
        ev_d  = 1;
        ev_r[0] = 1;
        for (int k = 0; k < n_eff; k++) begin
            ev_e[k] = ev_r[k] + ((sdly[k] > kdly[k]) ? sdly[k] : kdly[k]);
            ev_f[k] = ev_e[k] + ln + xtra[k];
            ev_s[k] = ev_f[k] + ddl[k];
            if (ev_s[k] < ev_e[k] + 1) ev_s[k] = ev_e[k] + 1;
            ev_u[k] = (ev_f[k] + 2 > ev_s[k] + 1) ? ev_f[k] + 2 : ev_s[k] + 1;
            ev_r[k+1] = ev_u[k] + 1;
            ev_d = ev_u[k] + 1;
        end
    endtask

    task automatic drive_env(input int t, input int ln, input bit live);
        logic src_rdy, snk_rdy, vld, sdone;
        int   cnt;
        src_rdy = 1'b1; snk_rdy = 1'b1; vld = 1'b0; sdone = 1'b0; cnt = 0;
        if (live) begin
            for (int k = 0; k < n_eff; k++) begin
                if (t >= ev_r[k] && t < ev_r[k] + sdly[k]) src_rdy = 1'b0;
                if (t >= ev_r[k] && t < ev_r[k] + kdly[k]) snk_rdy = 1'b0;
                if (t == ev_s[k]) sdone = 1'b1;
                if (t > ev_e[k] && t <= ev_f[k]) begin
                    if (t == ev_f[k]) begin
                        cnt = ln; vld = 1'b1;
                    end else begin
                        cnt = (t - ev_e[k] < ln) ? t - ev_e[k] : ln;
                        vld = (cnt != ln) ? 1'($urandom_range(0, 1)) : 1'b0;
                    end
                end
            end
        end
        bus_if.src_ready_i     = src_rdy;
        bus_if.sink_ready_i    = snk_rdy;
        bus_if.sink_done_i     = sdone;
        bus_if.eng_cnt_i       = LEN_W'(cnt);
        bus_if.eng_acc_valid_i = vld;
    endtask

    task automatic check_idle_after_abort();
        check_value("abort_busy",  32'(bus_if.busy_o), 32'd0);
        check_value("abort_idx",   32'(bus_if.iter_idx_o), 32'd0);
        check_value("abort_src",   32'(bus_if.src_req_start_o), 32'd0);
        check_value("abort_sink",  32'(bus_if.sink_req_start_o), 32'd0);
        check_value("abort_start", 32'(bus_if.eng_start_o), 32'd0);
        check_value("abort_en",    32'(bus_if.eng_enable_o), 32'd0);
        check_value("abort_done",  32'(bus_if.done_o), 32'd0);
    endtask

    // abort_kind: 0 none, 1 clear_i at ev_e[abort_iter]+abort_off, 2 rst_n at ev_f[abort_iter]+abort_off
    task automatic run(input string name, input int nb, input int ln, input int sh, input int sm,
                       input int abort_kind, input int abort_iter, input int abort_off,
                       input int repulse_off);
        int abort_t, repulse_t, last, n_starts, n_done;
        bit in_req, is_e, in_en, is_u;
        int idx;
        build_schedule(nb, ln);
        abort_t   = (abort_kind == 1) ? ev_e[abort_iter] + abort_off :
                    (abort_kind == 2) ? ev_f[abort_iter] + abort_off : -1;
        repulse_t = (repulse_off >= 0 && n_eff > 0) ? ev_e[0] + repulse_off : -1;
        last      = (abort_kind != 0) ? abort_t + 4 : ev_d + 2;
        n_starts  = 0;
        n_done    = 0;
        for (int t = 0; t <= last; t++) begin
            cur_t = t;
            bus_if.start_i = (t == 0 || t == repulse_t);
            if (t == 0) begin
                bus_if.nb_iter_i    = NB_ITER_W'(nb);
                bus_if.len_i        = LEN_W'(ln);
                bus_if.shift_i      = SHIFT_W'(sh);
                bus_if.simple_mul_i = 1'(sm);
            end else begin
                bus_if.nb_iter_i    = NB_ITER_W'($urandom);
                bus_if.len_i        = LEN_W'($urandom);
                bus_if.shift_i      = SHIFT_W'($urandom);
                bus_if.simple_mul_i = 1'($urandom);
            end
            bus_if.clear_i = (abort_kind == 1 && t == abort_t);
            rst_n = !(abort_kind == 2 && t == abort_t);
            drive_env(t, ln, !(abort_kind != 0 && t > abort_t));
            @(negedge clk);
            n_starts += int'(bus_if.eng_start_o);
            n_done   += int'(bus_if.done_o);
            if (abort_kind != 0 && t >= abort_t) begin
                if (t == abort_t && abort_kind == 1) begin
                    check_value("clr_eng_clear", 32'(bus_if.eng_clear_o), 32'd1);
                    check_value("clr_done", 32'(bus_if.done_o), 32'd0);
                end else if (t == abort_t) begin
                    check_value("rst_outputs", {bus_if.busy_o, bus_if.done_o, bus_if.eng_clear_o,
                                bus_if.eng_start_o, bus_if.eng_enable_o, bus_if.eng_simple_mul_o,
                                bus_if.src_req_start_o, bus_if.sink_req_start_o}, 32'd0);
                    check_value("rst_idx", 32'(bus_if.iter_idx_o), 32'd0);
                    check_value("rst_cfg", {bus_if.eng_len_o, bus_if.eng_shift_o}, 32'd0);
                end else begin
                    check_idle_after_abort();
                end
            end else begin
                in_req = 0; is_e = 0; in_en = 0; is_u = 0; idx = 0;
                for (int k = 0; k < n_eff; k++) begin
                    if (t >= ev_r[k] && t <= ev_e[k]) in_req = 1;
                    if (t == ev_e[k]) is_e = 1;
                    if (t > ev_e[k] && t < ev_u[k]) in_en = 1;
                    if (t == ev_u[k]) is_u = 1;
                    if (ev_u[k] < t) idx++;
                end
                check_value("busy",      32'(bus_if.busy_o), 32'(t >= 1 && t <= ev_d));
                check_value("done",      32'(bus_if.done_o), 32'(t == ev_d));
                check_value("src_req",   32'(bus_if.src_req_start_o), 32'(in_req));
                check_value("sink_req",  32'(bus_if.sink_req_start_o), 32'(in_req));
                check_value("eng_start", 32'(bus_if.eng_start_o), 32'(is_e));
                check_value("eng_en",    32'(bus_if.eng_enable_o), 32'(in_en));
                check_value("eng_clear", 32'(bus_if.eng_clear_o), 32'(t == 0 || is_u));
                if (t >= 1) begin
                    check_value("iter_idx", 32'(bus_if.iter_idx_o), 32'(idx));
                    check_value("eng_len",  32'(bus_if.eng_len_o), 32'(ln));
                    check_value("eng_shift", 32'(bus_if.eng_shift_o), 32'(sh));
                    check_value("eng_smul", 32'(bus_if.eng_simple_mul_o), 32'(sm));
                end
            end
            @(posedge clk);
            #1;
        end
        bus_if.start_i = 1'b0;
        bus_if.clear_i = 1'b0;
        rst_n = 1'b1;
        $display("run %-10s nb=%0d len=%0d shift=%0d smul=%0d abort=%0d eng_starts=%0d done_pulses=%0d cycles=%0d",
                 name, nb, ln, sh, sm, abort_kind, n_starts, n_done, last + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.start_i = 1'b0; bus_if.clear_i = 1'b0;
        bus_if.nb_iter_i = '0; bus_if.len_i = '0; bus_if.shift_i = '0; bus_if.simple_mul_i = 1'b0;
        bus_if.src_ready_i = 1'b0; bus_if.sink_ready_i = 1'b0; bus_if.sink_done_i = 1'b0;
        bus_if.eng_cnt_i = '0; bus_if.eng_acc_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_outputs", {bus_if.busy_o, bus_if.done_o, bus_if.eng_clear_o,
                    bus_if.eng_start_o, bus_if.eng_enable_o, bus_if.eng_simple_mul_o,
                    bus_if.src_req_start_o, bus_if.sink_req_start_o}, 32'd0);
        check_value("reset_idx", 32'(bus_if.iter_idx_o), 32'd0);
        check_value("reset_cfg", {bus_if.eng_len_o, bus_if.eng_shift_o}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_timing(0, 0, 0, 2);
        run("basic", 3, 4, 2, 0, 0, 0, 0, -1);
        run("nb_zero", 0, 4, 1, 0, 0, 0, 0, -1);
        run("len_zero", 3, 0, 1, 1, 0, 0, 0, -1);
        set_timing(5, 0, 0, 2);
        run("src_delay", 1, 4, 3, 0, 0, 0, 0, -1);
        set_timing(0, 0, 0, 0);
        run("same_cyc", 2, 3, 0, 1, 0, 0, 0, -1);
        set_timing(0, 0, 0, 2);
        run("clear", 4, 4, 1, 0, 1, 1, 2, -1);
        run("after_clr", 2, 2, 4, 1, 0, 0, 0, -1);
        set_timing(1, 2, 0, 3);
        run("repulse_rst", 3, 3, 5, 1, 2, 1, 1, 1);
        run("after_rst", 1, 5, 6, 0, 0, 0, 0, -1);

        for (int i = 0; i < 25; i++) begin
            rand_timing();
            run("random", int'($urandom_range(1, 5)), int'($urandom_range(1, 8)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), 0, 0, 0,
                (i % 3 == 0) ? 1 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
